alu_pipe_seq: RTL and testbench
===============================

Name: alu_pipe_seq

Overview:
- Parametrised, clocked successor to the team's combinational 32-bit ALU.
- Keeps the same 5-bit opcode map (0x00–0x11) and adds two iterative ops: unsigned multiply (MULU) and unsigned divide (DIVU).
- Operands enter and results leave through valid/ready handshakes. Results are registered, carry a tag, and set zero/overflow/illegal flags plus a sticky overflow bit.
- Sits between the decode/issue stage and writeback of the lab datapath.

Parameters:
- DATA_W, 32, operand/result width; power of two, ≥8.
- TAG_W, 4, width of the sideband tag carried with each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_enable  in  1  global enable; when low, no new operation is accepted.
- in_valid  in  1  operation present.
- in_ready  out  1  block can accept an operation this cycle.
- alu_op  in  5  opcode.
- src1  in  DATA_W  operand 1.
- src2  in  DATA_W  operand 2.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes the result.
- alu_out  out  DATA_W  result.
- alu_overflow  out  1  overflow of this result.
- alu_zero  out  1  alu_out == 0.
- out_illegal  out  1  opcode was unsupported.
- out_tag  out  TAG_W  tag of this result.
- busy  out  1  iterative op in progress.
- ovf_sticky  out  1  set by any delivered overflow.
- clr_sticky  in  1  clears ovf_sticky.

Behaviour:
- Reset: all outputs except in_ready are 0 and the FSM goes to IDLE; in_ready is 0 while rst is high. Reset asserted mid-MULU/DIVU aborts the op with no result.
- Accept condition: in_valid && in_ready.
  - in_ready = alu_enable && state==IDLE && (!out_valid || out_ready).
  - A full output register may be refilled in the same cycle it drains.
- Output register: holds its contents and flags while out_valid && !out_ready. out_valid falls on drain if nothing new is loaded.
- Single-cycle ops (0x00–0x11, illegal codes): accepted in cycle N → out_valid in cycle N+1.
- Op semantics:
  - ADD/SUB: signed overflow as in the existing ALU.
  - AND/OR/XOR/NOR/NOT/NAND: bitwise.
  - SRL: arithmetic right shift.
  - SRLU: logical right shift.
  - SLL: left shift.
  - ROTR/ROTL: rotate.
  - MAX/MIN/SLTS: signed compare; SLTS returns 1 or 0.
  - ABS: two's-complement magnitude; overflow=1 only when src1 = most-negative value (result = src1).
  - ADDU: overflow = carry-out.
- Shift/rotate amount is src2[log2(DATA_W)-1:0]; higher bits are ignored.
- Overflow is 0 for all ops not listed above.
- FSM states: IDLE, MUL, DIV.
  - Accepting MULU (5'b10010) or DIVU (5'b10011) loads operands and tag, sets counter=DATA_W, and enters MUL or DIV. busy=1 from N+1.
  - One shift-add or restoring-divide step per cycle. On the cycle counter reaches 1, the result is loaded and the FSM returns to IDLE.
  - out_valid appears at N+DATA_W+1; busy drops the same cycle.
- MULU: alu_out = low DATA_W bits of the product; overflow = (high half ≠ 0).
- DIVU: alu_out = quotient. Divide by zero still takes the full latency, returns all ones, overflow=1.
- Illegal opcode (0x14–0x1F): alu_out=0, overflow=0, out_illegal=1, single-cycle latency.
- ovf_sticky:
  - Sets on the cycle a result with alu_overflow=1 is loaded.
  - clr_sticky clears it.
  - If set and clear occur in the same cycle, set wins.
- alu_enable falling mid-MUL/DIV does not abort the op.
- Results are always delivered in acceptance order. No reordering is possible: only one op is in flight at a time.

Test Plan:
- DATA_W=32, ADD src1=0x7FFFFFFF, src2=0x00000001, out_ready=1 → cycle N+1: alu_out=0x80000000, alu_overflow=1, ovf_sticky=1; then clr_sticky=1 → ovf_sticky=0 next cycle.
- MULU 0x00010000 × 0x00010000 accepted at N → busy=1 for N+1..N+32, in_ready=0; at N+33: alu_out=0, overflow=1. MULU 7×6 → 42, overflow=0.
- DIVU 100/7 → alu_out=14, overflow=0. DIVU 5/0 → alu_out=0xFFFFFFFF, overflow=1, latency 33.
- ROTL 0x80000001 by src2=36 → 0x00000018. SRL 0x80000000 by 4 → 0xF8000000. SRLU 0x80000000 by 4 → 0x08000000. ABS 0x80000000 → 0x80000000 with overflow=1.
- Backpressure: hold out_ready=0 after a SUB result (tag 3) → in_ready=0 and the result is stable; raise out_ready → tag 3 drains and a pending ADD (tag 4) is accepted in the same cycle, appearing next cycle.
- Assert rst during DIV cycle 10 → immediately out_valid=0, busy=0, ovf_sticky=0. After release, opcode 0x1F → out_illegal=1, alu_out=0, alu_zero=1.

Source files
------------

// File: rtl/alu_pipe_seq_if.sv
// Handshake bundle between the issue stage, the ALU and writeback.
// The issuer drives operands and out_ready; the ALU drives the result side.
interface alu_pipe_seq_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        alu_op;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_out;
  logic              alu_overflow;
  logic              alu_zero;
  logic              out_illegal;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, alu_op, src1, src2, in_tag, out_ready,
    input  in_ready, out_valid, alu_out, alu_overflow, alu_zero, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, alu_op, src1, src2, in_tag, out_ready,
    output in_ready, out_valid, alu_out, alu_overflow, alu_zero, out_illegal, out_tag
  );
endinterface

// File: rtl/alu_pipe_seq.sv
// Registered ALU with valid/ready handshakes: single-cycle ops plus iterative
// shift-add multiply and restoring divide, one operation in flight at a time.
module alu_pipe_seq #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alu_enable,
  alu_pipe_seq_if.slave  bus,
  output logic           busy,
  output logic           ovf_sticky,
  input  logic           clr_sticky
);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W + 1;
  localparam int MSB   = DATA_W - 1;

  localparam logic [4:0] OP_ADD  = 5'h00, OP_SUB  = 5'h01, OP_AND  = 5'h02, OP_OR   = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04, OP_NOR  = 5'h05, OP_NOT  = 5'h06, OP_NAND = 5'h07;
  localparam logic [4:0] OP_SRL  = 5'h08, OP_SRLU = 5'h09, OP_SLL  = 5'h0A, OP_ROTR = 5'h0B;
  localparam logic [4:0] OP_ROTL = 5'h0C, OP_MAX  = 5'h0D, OP_MIN  = 5'h0E, OP_SLTS = 5'h0F;
  localparam logic [4:0] OP_ABS  = 5'h10, OP_ADDU = 5'h11, OP_MULU = 5'h12, OP_DIVU = 5'h13;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  // Returns {illegal, overflow, result} for every non-iterative opcode.
  function automatic logic [DATA_W+1:0] alu_single(input logic [4:0] op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [DATA_W-1:0]        r;
    logic [DATA_W:0]          wide;
    logic [2*DATA_W-1:0]      dbl;
    logic [SH_W-1:0]          sh;
    logic                     ovf;
    logic                     ill;
    sa   = a;
    sb   = b;
    sh   = b[SH_W-1:0];
    r    = '0;
    wide = '0;
    dbl  = '0;
    ovf  = 1'b0;
    ill  = 1'b0;
    case (op)
      OP_ADD:  begin r = a + b; ovf = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]); end
      OP_SUB:  begin r = a - b; ovf = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_SRL:  r = sa >>> sh;
      OP_SRLU: r = a >> sh;
      OP_SLL:  r = a << sh;
      OP_ROTR: begin dbl = {a, a} >> sh; r = dbl[DATA_W-1:0]; end
      OP_ROTL: begin dbl = {a, a} << sh; r = dbl[2*DATA_W-1:DATA_W]; end
      OP_MAX:  r = (sa > sb) ? a : b;
      OP_MIN:  r = (sa < sb) ? a : b;
      OP_SLTS: r = DATA_W'(sa < sb);
      OP_ABS:  begin r = a[MSB] ? -a : a; ovf = (a == {1'b1, {(DATA_W-1){1'b0}}}); end
      OP_ADDU: begin wide = {1'b0, a} + {1'b0, b}; r = wide[DATA_W-1:0]; ovf = wide[DATA_W]; end
      default: ill = 1'b1;
    endcase
    return {ill, ovf, r};
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  // MUL: hi = partial product, lo = multiplier shifting out / product low half.
  // DIV: hi = remainder, lo = dividend shifting out / quotient shifting in.
  logic [DATA_W-1:0] hi_p1;
  logic [DATA_W-1:0] lo_p1;
  logic [DATA_W-1:0] opb_p1;
  logic [TAG_W-1:0]  tag_p1;

  logic              accept;
  logic              iter_op;
  logic              last_step;
  logic [DATA_W+1:0] single;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_trial;
  logic [DATA_W-1:0] mul_hi_nx, mul_lo_nx, div_rem_nx, div_q_nx;
  logic              load;
  logic [DATA_W-1:0] load_res;
  logic              load_ovf, load_ill;
  logic [TAG_W-1:0]  load_tag;

  assign bus.in_ready = !rst && alu_enable && (state == IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign iter_op      = (bus.alu_op == OP_MULU) || (bus.alu_op == OP_DIVU);
  assign last_step    = (state != IDLE) && (cnt == CNT_W'(1));
  assign single       = alu_single(bus.alu_op, bus.src1, bus.src2);
  assign busy         = (state != IDLE);

  always_comb begin
    mul_sum   = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, opb_p1} : '0);
    mul_hi_nx = mul_sum[DATA_W:1];
    mul_lo_nx = {mul_sum[0], lo_p1[DATA_W-1:1]};
    div_shift = {hi_p1, lo_p1[DATA_W-1]};
    div_trial = div_shift - {1'b0, opb_p1};
    if (div_trial[DATA_W]) begin
      div_rem_nx = div_shift[DATA_W-1:0];
      div_q_nx   = {lo_p1[DATA_W-2:0], 1'b0};
    end else begin
      div_rem_nx = div_trial[DATA_W-1:0];
      div_q_nx   = {lo_p1[DATA_W-2:0], 1'b1};
    end
  end

  // Result register source: finishing iterative op, else a fresh single-cycle op.
  always_comb begin
    load     = 1'b0;
    load_res = single[DATA_W-1:0];
    load_ovf = single[DATA_W];
    load_ill = single[DATA_W+1];
    load_tag = bus.in_tag;
    if (last_step && state == MUL) begin
      load     = 1'b1;
      load_res = mul_lo_nx;
      load_ovf = |mul_hi_nx;
      load_ill = 1'b0;
      load_tag = tag_p1;
    end else if (last_step && state == DIV) begin
      load     = 1'b1;
      load_res = div_q_nx;
      load_ovf = (opb_p1 == '0);
      load_ill = 1'b0;
      load_tag = tag_p1;
    end else if (accept && !iter_op) begin
      load = 1'b1;
    end
  end

  // Stage p1: iterative operand registers
  always_ff @(posedge clk) begin
    if (accept && iter_op) begin
      hi_p1  <= '0;
      lo_p1  <= bus.src1;
      opb_p1 <= bus.src2;
      tag_p1 <= bus.in_tag;
    end else if (state == MUL) begin
      hi_p1 <= mul_hi_nx;
      lo_p1 <= mul_lo_nx;
    end else if (state == DIV) begin
      hi_p1 <= div_rem_nx;
      lo_p1 <= div_q_nx;
    end
  end

  // Stage p2: FSM, result register and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.out_valid    <= 1'b0;
      bus.alu_out      <= '0;
      bus.alu_overflow <= 1'b0;
      bus.alu_zero     <= 1'b0;
      bus.out_illegal  <= 1'b0;
      bus.out_tag      <= '0;
      ovf_sticky       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && bus.alu_op == OP_MULU) begin
            state <= MUL;
            cnt   <= CNT_W'(DATA_W);
          end else if (accept && bus.alu_op == OP_DIVU) begin
            state <= DIV;
            cnt   <= CNT_W'(DATA_W);
          end
        end
        MUL, DIV: begin
          cnt <= cnt - CNT_W'(1);
          if (last_step) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        bus.out_valid    <= 1'b1;
        bus.alu_out      <= load_res;
        bus.alu_overflow <= load_ovf;
        bus.alu_zero     <= (load_res == '0);
        bus.out_illegal  <= load_ill;
        bus.out_tag      <= load_tag;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (load && load_ovf)  ovf_sticky <= 1'b1;
      else if (clr_sticky)   ovf_sticky <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe_seq.sv
// Self-checking bench for alu_pipe_seq: directed vector table, hand-written
// handshake/reset sequences and randomized ops against an arithmetic model.
module tb_alu_pipe_seq;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int NV = 28;

  localparam logic [4:0] OP_ADD  = 5'h00, OP_SUB  = 5'h01, OP_AND  = 5'h02, OP_OR   = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04, OP_NOR  = 5'h05, OP_NOT  = 5'h06, OP_NAND = 5'h07;
  localparam logic [4:0] OP_SRL  = 5'h08, OP_SRLU = 5'h09, OP_SLL  = 5'h0A, OP_ROTR = 5'h0B;
  localparam logic [4:0] OP_ROTL = 5'h0C, OP_MAX  = 5'h0D, OP_MIN  = 5'h0E, OP_SLTS = 5'h0F;
  localparam logic [4:0] OP_ABS  = 5'h10, OP_ADDU = 5'h11, OP_MULU = 5'h12, OP_DIVU = 5'h13;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ovf;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst, alu_enable, busy, ovf_sticky, clr_sticky;
  int   checks = 0;
  int   failures = 0;

  alu_pipe_seq_if #(.DATA_W(DW), .TAG_W(TW)) bus();

  alu_pipe_seq #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .alu_enable(alu_enable), .bus(bus),
    .busy(busy), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic il, input logic o, input logic z,
                                     input logic [3:0] t, input logic [31:0] r);
    return {25'b0, il, o, z, t, r};
  endfunction

  // Reference model built from plain integer arithmetic.
  function automatic void ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o, output logic il);
    longint          sa, sb, s;
    longint unsigned ua, ub, u;
    int              sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    sh = int'(b[4:0]);
    r  = '0;
    o  = 1'b0;
    il = 1'b0;
    case (op)
      OP_ADD:  begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_SUB:  begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_SRL:  begin s = sa >>> sh; r = s[31:0]; end
      OP_SRLU: r = a >> sh;
      OP_SLL:  begin u = ua << sh; r = u[31:0]; end
      OP_ROTR: begin r = a; for (int k = 0; k < sh; k++) r = {r[0], r[31:1]}; end
      OP_ROTL: begin r = a; for (int k = 0; k < sh; k++) r = {r[30:0], r[31]}; end
      OP_MAX:  r = (sa > sb) ? a : b;
      OP_MIN:  r = (sa < sb) ? a : b;
      OP_SLTS: r = (sa < sb) ? 32'd1 : 32'd0;
      OP_ABS:  begin s = (sa < 0) ? -sa : sa; r = s[31:0]; o = (s > 64'sd2147483647); end
      OP_ADDU: begin u = ua + ub; r = u[31:0]; o = u[32]; end
      OP_MULU: begin u = ua * ub; r = u[31:0]; o = (u[63:32] != 32'd0); end
      OP_DIVU: begin
        if (b == 32'd0) begin r = 32'hFFFF_FFFF; o = 1'b1; end
        else begin u = ua / ub; r = u[31:0]; end
      end
      default: il = 1'b1;
    endcase
  endfunction

  // Issue one op with out_ready high, return the result and its latency in cycles.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, output logic [31:0] r, output logic o,
                        output logic il, output logic z, output logic [3:0] t, output int lat);
    int n;
    r = '0; o = 1'b0; il = 1'b0; z = 1'b0; t = '0; lat = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = op; bus.src1 = a; bus.src2 = b;
    bus.in_tag = tag; bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 100 cycles required 1");
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!bus.out_valid) begin
      checks++; failures++;
      $display("FAIL out_valid_timeout: got out_valid=0 for 100 cycles required 1");
      return;
    end
    r = bus.alu_out; o = bus.alu_overflow; il = bus.out_illegal; z = bus.alu_zero; t = bus.out_tag;
  endtask

  vec_t        vecs [NV];
  logic [31:0] r, er;
  logic        o, il, z, eo, eil, sticky_m;
  logic [3:0]  t;
  int          lat, elat, bad;

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    vecs[0]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
    vecs[1]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[3]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
    vecs[4]  = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    vecs[5]  = '{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1'b0};
    vecs[6]  = '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0};
    vecs[7]  = '{OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[8]  = '{OP_NOT,  32'h1234_5678, 32'h0000_0000, 32'hEDCB_A987, 1'b0, 1'b0};
    vecs[9]  = '{OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[10] = '{OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0};
    vecs[11] = '{OP_SRLU, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0};
    vecs[12] = '{OP_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0};
    vecs[13] = '{OP_ROTR, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
    vecs[14] = '{OP_ROTL, 32'h8000_0001, 32'h0000_0024, 32'h0000_0018, 1'b0, 1'b0};
    vecs[15] = '{OP_MAX,  32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0};
    vecs[16] = '{OP_MIN,  32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[17] = '{OP_SLTS, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0001, 1'b0, 1'b0};
    vecs[18] = '{OP_SLTS, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[19] = '{OP_ABS,  32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0};
    vecs[20] = '{OP_ABS,  32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0005, 1'b0, 1'b0};
    vecs[21] = '{OP_ADDU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[22] = '{OP_MULU, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0, 1'b0};
    vecs[23] = '{OP_MULU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[24] = '{OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 1'b0};
    vecs[25] = '{OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[26] = '{5'h14,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
    vecs[27] = '{5'h1F,   32'h1234_5678, 32'h8765_4321, 32'h0000_0000, 1'b0, 1'b1};

    rst = 1'b1; alu_enable = 1'b1; clr_sticky = 1'b0;
    bus.in_valid = 1'b0; bus.alu_op = '0; bus.src1 = '0; bus.src2 = '0;
    bus.in_tag = '0; bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", pk(bus.out_illegal, bus.alu_overflow, bus.alu_zero, bus.out_tag, bus.alu_out), 64'h0);
    check("reset_ctrl", {60'b0, bus.in_ready, bus.out_valid, busy, ovf_sticky}, 64'h0);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", {63'b0, bus.in_ready}, 64'h1);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), r, o, il, z, t, lat);
      check($sformatf("vec%0d_op%0h", i, vecs[i].op), pk(il, o, z, t, r),
            pk(vecs[i].ill, vecs[i].ovf, vecs[i].r == 32'h0, 4'(i), vecs[i].r));
      elat = (vecs[i].op == OP_MULU || vecs[i].op == OP_DIVU) ? 33 : 1;
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(elat));
    end

    // ADD overflow sets sticky, clr_sticky clears it
    @(negedge clk); clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    check("sticky_precleared", {63'b0, ovf_sticky}, 64'h0);
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 4'h1, r, o, il, z, t, lat);
    check("add_ovf_result", pk(il, o, z, t, r), pk(1'b0, 1'b1, 1'b0, 4'h1, 32'h8000_0000));
    check("add_ovf_sticky_set", {63'b0, ovf_sticky}, 64'h1);
    clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    check("sticky_cleared", {63'b0, ovf_sticky}, 64'h0);

    // MULU busy window, alu_enable dropped mid-op must not abort
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = OP_MULU; bus.src1 = 32'h0001_0000;
    bus.src2 = 32'h0001_0000; bus.in_tag = 4'h9; bus.out_ready = 1'b1;
    #1;
    check("mulu_in_ready_idle", {63'b0, bus.in_ready}, 64'h1);
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 1)  bus.in_valid = 1'b0;
      if (i == 5)  alu_enable = 1'b0;
      if (i == 10) alu_enable = 1'b1;
      if (!busy || bus.in_ready || bus.out_valid) bad++;
    end
    check("mulu_busy_window", 64'(bad), 64'h0);
    @(negedge clk);
    check("mulu_done_ctrl", {62'b0, bus.out_valid, busy}, 64'h2);
    check("mulu_done_result", pk(bus.out_illegal, bus.alu_overflow, bus.alu_zero, bus.out_tag, bus.alu_out),
          pk(1'b0, 1'b1, 1'b1, 4'h9, 32'h0));

    // Backpressure: SUB tag 3 held, ADD tag 4 pending, accepted on drain
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = OP_SUB; bus.src1 = 32'd10; bus.src2 = 32'd3;
    bus.in_tag = 4'h3; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.alu_op = OP_ADD; bus.src1 = 32'd2; bus.src2 = 32'd2; bus.in_tag = 4'h4;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.in_ready || !bus.out_valid || bus.out_tag != 4'h3 || bus.alu_out != 32'd7) bad++;
    end
    check("backpressure_hold", 64'(bad), 64'h0);
    bus.out_ready = 1'b1;
    #1;
    check("refill_in_ready", {63'b0, bus.in_ready}, 64'h1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("refill_result", {27'b0, bus.out_valid, bus.out_tag, bus.alu_out}, {27'b0, 1'b1, 4'h4, 32'd4});
    @(negedge clk);
    check("drain_out_valid", {63'b0, bus.out_valid}, 64'h0);

    // Randomized ops against the reference model
    clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    sticky_m = 1'b0;
    for (int i = 0; i < 150; i++) begin
      logic [4:0]  rop;
      logic [31:0] ra, rb;
      logic [3:0]  rtag;
      rop  = 5'($urandom_range(0, 31));
      ra   = pick_operand();
      rb   = pick_operand();
      rtag = 4'($urandom_range(0, 15));
      ref_alu(rop, ra, rb, er, eo, eil);
      run_op(rop, ra, rb, rtag, r, o, il, z, t, lat);
      sticky_m = sticky_m | eo;
      check($sformatf("rand%0d_op%0h_a%0h_b%0h", i, rop, ra, rb), pk(il, o, z, t, r),
            pk(eil, eo, er == 32'h0, rtag, er));
      elat = (rop == OP_MULU || rop == OP_DIVU) ? 33 : 1;
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(elat));
      check($sformatf("rand%0d_sticky", i), {63'b0, ovf_sticky}, {63'b0, sticky_m});
    end

    // Reset during DIV aborts the op with no result
    run_op(OP_ADDU, 32'hFFFF_FFFF, 32'h2, 4'h2, r, o, il, z, t, lat);
    check("sticky_before_reset", {63'b0, ovf_sticky}, 64'h1);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = OP_DIVU; bus.src1 = 32'd1000; bus.src2 = 32'd3;
    bus.in_tag = 4'h6; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("div_busy_before_reset", {63'b0, busy}, 64'h1);
    rst = 1'b1;
    #1;
    check("reset_mid_div", {60'b0, bus.out_valid, busy, ovf_sticky, bus.in_ready}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid || busy) bad++;
    end
    check("no_result_after_abort", 64'(bad), 64'h0);

    // Illegal opcode after reset
    run_op(5'h1F, 32'hDEAD_BEEF, 32'h1, 4'hA, r, o, il, z, t, lat);
    check("illegal_1f", pk(il, o, z, t, r), pk(1'b1, 1'b0, 1'b1, 4'hA, 32'h0));
    check("illegal_latency", 64'(lat), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
